// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU issue arbiter: ALU_Control codes, FSM encoding,
// and the latency-class helper.
package alu_arb_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  // Only MUL and DIV take the long settle path; every other code is simple.
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_issue_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Time-shares one external ALU between NUM_REQ requesters: round-robin issue,
// per-op settle wait, then a valid/ready result return to the owner.
//
//   state   | meaning
//   IDLE    | ready to grant; req_ready shows the round-robin pick
//   EXEC    | operands held on alu_*, settle counter running down
//   RESP    | result captured, rsp_valid to owner until it accepts
module alu_issue_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int SIMPLE_LAT = 1,
  parameter int MULDIV_LAT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  input  logic [3*NUM_REQ-1:0]   req_op,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [31:0]            rsp_result,
  output logic                   rsp_zero,
  output logic [31:0]            alu_a,
  output logic [31:0]            alu_b,
  output logic [2:0]             alu_ctrl,
  input  logic [31:0]            alu_result,
  input  logic                   alu_zero,
  output logic                   busy
);

  localparam int IW      = $clog2(NUM_REQ);
  localparam int MAX_LAT = (MULDIV_LAT > SIMPLE_LAT) ? MULDIV_LAT : SIMPLE_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [CNT_W-1:0] SIMPLE_CNT = CNT_W'(SIMPLE_LAT - 1);
  localparam logic [CNT_W-1:0] MULDIV_CNT = CNT_W'(MULDIV_LAT - 1);
  localparam logic [IW-1:0]    LAST_IDX   = IW'(NUM_REQ - 1);

  arb_state_t       state_q;
  arb_state_t       state_d;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    owner;
  logic [CNT_W-1:0] cnt;

  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      grant_idx;
  logic               grant_any;
  logic [31:0]        sel_a;
  logic [31:0]        sel_b;
  logic [2:0]         sel_op;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  assign sel_a  = req_a[32*int'(grant_idx) +: 32];
  assign sel_b  = req_b[32*int'(grant_idx) +: 32];
  assign sel_op = req_op[3*int'(grant_idx) +: 3];
  assign busy   = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    rsp_valid = '0;
    case (state_q)
      ST_IDLE: begin
        req_ready = grant;
        if (grant_any) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (cnt == '0) state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid[owner] = 1'b1;
        if (rsp_ready[owner]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand, owner, counter and result registers; only touched on FSM events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      owner      <= '0;
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= OP_AND;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_any) begin
            alu_a    <= sel_a;
            alu_b    <= sel_b;
            alu_ctrl <= sel_op;
            owner    <= grant_idx;
            cnt      <= is_muldiv(sel_op) ? MULDIV_CNT : SIMPLE_CNT;
          end
        end
        ST_EXEC: begin
          if (cnt == '0) begin
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready[owner]) rr_ptr <= (owner == LAST_IDX) ? '0 : owner + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter with a behavioural ALU on the alu_* side.
module tb_alu_issue_arbiter;
  import alu_arb_pkg::*;

  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [32*N-1:0] req_a = '0;
  logic [32*N-1:0] req_b = '0;
  logic [3*N-1:0] req_op = '0;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready = '0;
  logic [31:0]    rsp_result;
  logic           rsp_zero;
  logic [31:0]    alu_a, alu_b;
  logic [2:0]     alu_ctrl;
  logic [31:0]    alu_result;
  logic           alu_zero;
  logic           busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_arbiter #(.NUM_REQ(N), .SIMPLE_LAT(1), .MULDIV_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy)
  );

  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      OP_AND: alu_result = alu_a & alu_b;
      OP_OR:  alu_result = alu_a | alu_b;
      OP_ADD: alu_result = alu_a + alu_b;
      OP_MUL: alu_result = alu_a * alu_b;
      OP_DIV: alu_result = (alu_b == 0) ? 32'hFFFF_FFFF : alu_a / alu_b;
      OP_SLL: alu_result = alu_a << alu_b[4:0];
      OP_SUB: alu_result = alu_a - alu_b;
      OP_SLT: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_result = '0;
    endcase
  end
  assign alu_zero = (alu_result == 32'd0);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready got %b want 00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid got %b want 00", rsp_valid); end
    checks++; if (rsp_result !== 32'd0) begin errors++; $display("FAIL rst_rsp_result got %h want 0", rsp_result); end
    checks++; if ({alu_a, alu_b, alu_ctrl} !== 67'd0) begin errors++; $display("FAIL rst_alu_regs got %h/%h/%b want 0", alu_a, alu_b, alu_ctrl); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    req_a[31:0] = 32'd5; req_b[31:0] = 32'd7; req_op[2:0] = OP_ADD; req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL add_grant got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00;
    checks++; if (busy !== 1'b1 || rsp_valid !== 2'b00) begin errors++; $display("FAIL add_exec busy=%b rsp_valid=%b want 1/00", busy, rsp_valid); end
    checks++; if (alu_a !== 32'd5 || alu_b !== 32'd7 || alu_ctrl !== OP_ADD) begin errors++; $display("FAIL add_operands got %h %h %b want 5 7 010", alu_a, alu_b, alu_ctrl); end
    tick();
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL add_rsp_valid got %b want 01 at T+2", rsp_valid); end
    checks++; if (rsp_result !== 32'd12 || rsp_zero !== 1'b0) begin errors++; $display("FAIL add_result got %h z=%b want 0000000c z=0", rsp_result, rsp_zero); end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    checks++; if (busy !== 1'b0 || rsp_valid !== 2'b00) begin errors++; $display("FAIL add_done busy=%b rsp_valid=%b want 0/00", busy, rsp_valid); end
  endtask

  task automatic test_mul();
    req_a[63:32] = 32'hFFFF_FFFD; req_b[63:32] = 32'd4; req_op[5:3] = OP_MUL; req_valid = 2'b10;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL mul_grant got %b want 10", req_ready); end
    tick();
    req_valid = 2'b00;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (rsp_valid !== 2'b00 || busy !== 1'b1) begin errors++; $display("FAIL mul_exec_T+%0d rsp_valid=%b busy=%b want 00/1", i, rsp_valid, busy); end
      tick();
    end
    checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL mul_rsp_valid got %b want 10 at T+5", rsp_valid); end
    checks++; if (rsp_result !== 32'hFFFF_FFF4) begin errors++; $display("FAIL mul_result got %h want fffffff4", rsp_result); end
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_g;
    logic [31:0] exp_r;
    int n;
    req_a = {32'd4, 32'd1}; req_b = {32'd1, 32'd1}; req_op = {OP_OR, OP_ADD}; req_valid = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_r = (i % 2 == 0) ? 32'd2 : 32'd5;
      checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL rr_grant%0d got %b want %b", i, req_ready, exp_g); end
      tick();
      n = 0;
      while (rsp_valid === 2'b00 && n < 10) begin
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rr_ready_busy%0d got %b want 00", i, req_ready); end
        tick();
        n++;
      end
      checks++; if (rsp_valid !== exp_g) begin errors++; $display("FAIL rr_rsp%0d got %b want %b", i, rsp_valid, exp_g); end
      checks++; if (rsp_result !== exp_r) begin errors++; $display("FAIL rr_result%0d got %h want %h", i, rsp_result, exp_r); end
      rsp_ready = exp_g;
      tick();
      rsp_ready = 2'b00;
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_hold();
    int n;
    req_a[31:0] = 32'd9; req_b[31:0] = 32'd9; req_op[2:0] = OP_SUB; req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL hold_grant got %b want 01", req_ready); end
    tick();
    req_a[63:32] = 32'h0000_00F0; req_b[63:32] = 32'h0000_003C; req_op[5:3] = OP_AND; req_valid = 2'b10;
    n = 0;
    while (rsp_valid === 2'b00 && n < 10) begin tick(); n++; end
    for (int i = 0; i < 10; i++) begin
      checks++; if (rsp_valid !== 2'b01 || busy !== 1'b1) begin errors++; $display("FAIL hold_valid%0d rsp_valid=%b busy=%b want 01/1", i, rsp_valid, busy); end
      checks++; if (rsp_zero !== 1'b1 || rsp_result !== 32'd0) begin errors++; $display("FAIL hold_zero%0d got z=%b r=%h want 1/0", i, rsp_zero, rsp_result); end
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL hold_ready%0d got %b want 00", i, req_ready); end
      tick();
    end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL hold_next_grant got %b want 10", req_ready); end
    tick();
    req_valid = 2'b00;
    n = 0;
    while (rsp_valid === 2'b00 && n < 10) begin tick(); n++; end
    checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL hold_next_rsp got %b want 10", rsp_valid); end
    checks++; if (rsp_result !== 32'h30 || rsp_zero !== 1'b0) begin errors++; $display("FAIL hold_next_result got %h z=%b want 30 z=0", rsp_result, rsp_zero); end
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;
  endtask

  task automatic test_ignore_other_ready();
    int n;
    req_a[31:0] = 32'd1; req_b[31:0] = 32'd4; req_op[2:0] = OP_SLL; req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL ign_grant got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00;
    n = 0;
    while (rsp_valid === 2'b00 && n < 10) begin tick(); n++; end
    rsp_ready = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (rsp_valid !== 2'b01 || busy !== 1'b1) begin errors++; $display("FAIL ign_persist%0d rsp_valid=%b busy=%b want 01/1", i, rsp_valid, busy); end
    end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL ign_release rsp_valid=%b busy=%b want 00/0", rsp_valid, busy); end
    checks++; if (rsp_result !== 32'd16) begin errors++; $display("FAIL ign_result_held got %h want 10", rsp_result); end
  endtask

  task automatic test_reset_mid_exec();
    req_a[31:0] = 32'd100; req_b[31:0] = 32'd7; req_op[2:0] = OP_DIV; req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rstx_grant got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00;
    tick();
    checks++; if (busy !== 1'b1 || alu_ctrl !== OP_DIV) begin errors++; $display("FAIL rstx_in_exec busy=%b ctrl=%b want 1/100", busy, alu_ctrl); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || rsp_valid !== 2'b00 || req_ready !== 2'b00) begin errors++; $display("FAIL rstx_ctrl busy=%b rsp_valid=%b req_ready=%b want 0/00/00", busy, rsp_valid, req_ready); end
    checks++; if (rsp_result !== 32'd0 || rsp_zero !== 1'b0) begin errors++; $display("FAIL rstx_rsp got %h z=%b want 0/0", rsp_result, rsp_zero); end
    checks++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_ctrl !== 3'b000) begin errors++; $display("FAIL rstx_alu got %h %h %b want 0 0 000", alu_a, alu_b, alu_ctrl); end
    tick();
    rst_n = 1'b1;
    tick();
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rstx_ptr got %b want 01", req_ready); end
    req_valid = 2'b00;
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_round_robin();
    test_hold();
    test_ignore_other_ready();
    test_reset_mid_exec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
